// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds op encodings, the control FSM states and the op-decoding helpers.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } mdu_state_e;

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV) ||
               (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

    function automatic logic mdu_is_acc(input logic [2:0] op);
        return (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

    function automatic logic mdu_is_sub(input logic [2:0] op);
        return (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master side issues operations; the slave side is the engine itself.
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic [2:0]         op_i;
    logic               start_i;
    logic               annul_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic [2*WIDTH-1:0] hilo_i;
    logic               busy_o;
    logic               ready_o;
    logic [2*WIDTH-1:0] result_o;
    logic               div_by_zero_o;

    modport master (
        output op_i, start_i, annul_i, a_i, b_i, hilo_i,
        input  busy_o, ready_o, result_o, div_by_zero_o
    );

    modport slave (
        input  op_i, start_i, annul_i, a_i, b_i, hilo_i,
        output busy_o, ready_o, result_o, div_by_zero_o
    );
endinterface

// File: rtl/mdu_iterative_div_radix2.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
// The divisor is WIDTH+1 bits wide so a negated INT_MIN magnitude is held exactly.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   dsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // The partial remainder stays below the divisor, so the difference always fits WIDTH bits.
    assign shifted = {rem, dq[WIDTH-1]};
    assign fits    = (shifted >= dsr);
    assign diff    = WIDTH'(shifted - dsr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq  <= '0;
            rem <= '0;
            dsr <= '0;
        end else if (load) begin
            dq  <= dividend;
            rem <= '0;
            dsr <= divisor;
        end else if (step) begin
            rem <= fits ? diff : shifted[WIDTH-1:0];
            dq  <= {dq[WIDTH-2:0], fits};
        end
    end

    assign quotient  = dq;
    assign remainder = rem;

endmodule

// File: rtl/mdu_iterative.sv
// Handshaked multiply/divide engine producing the {HI,LO} value for the execute stage.
// Owns the control FSM, the multiplier pipeline, divide sign fix-up and flush handling.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mdu_iterative_if.slave bus
);

    localparam int W2      = 2 * WIDTH;
    localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [W2-1:0]     hilo_q;
    logic              busy_q;
    logic              ready_q;
    logic              dbz_q;
    logic [W2-1:0]     result_q;

    logic [W2-1:0]     pipe [MUL_STAGES];
    logic [W2-1:0]     ext_a;
    logic [W2-1:0]     ext_b;
    logic [W2-1:0]     raw_prod;
    logic              sgn;

    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    b_ext;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH:0]    b_mag;
    logic [WIDTH-1:0]  q_mag;
    logic [WIDTH-1:0]  r_mag;
    logic [WIDTH-1:0]  q_fix;
    logic [WIDTH-1:0]  r_fix;
    logic              a_neg;
    logic              b_neg;
    logic              div_load;
    logic              div_step;

    // Sign- or zero-extending to 2*WIDTH lets one unsigned multiply serve both op flavours.
    assign sgn      = mdu_is_signed(op_q);
    assign ext_a    = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b    = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign raw_prod = ext_a * ext_b;

    function automatic logic [W2-1:0] accumulate(input logic [W2-1:0] p);
        if (!mdu_is_acc(op_q)) begin
            return p;
        end else if (mdu_is_sub(op_q)) begin
            return hilo_q - p;
        end else begin
            return hilo_q + p;
        end
    endfunction

    // Product enters the first stage; the accumulate is folded into the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= (MUL_STAGES == 1) ? accumulate(raw_prod) : raw_prod;
            for (int i = 1; i < MUL_STAGES; i++) begin
                pipe[i] <= (i == MUL_STAGES - 1) ? accumulate(pipe[i-1]) : pipe[i-1];
            end
        end
    end

    assign a_neg = sgn & a_q[WIDTH-1];
    assign b_neg = sgn & b_q[WIDTH-1];
    assign a_ext = {a_neg, a_q};
    assign b_ext = {b_neg, b_q};
    assign a_mag = WIDTH'(a_neg ? -a_ext : a_ext);
    assign b_mag = b_neg ? -b_ext : b_ext;

    assign div_load = (state == DIV) && (cnt == '0);
    assign div_step = (state == DIV) && (cnt != '0);

    div_radix2 #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (q_mag),
        .remainder(r_mag)
    );

    // Quotient truncates toward zero; the remainder follows the dividend's sign.
    assign q_fix = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_fix = a_neg ? -r_mag : r_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= MDU_MULT;
            a_q      <= '0;
            b_q      <= '0;
            hilo_q   <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
            if (bus.annul_i) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start_i) begin
                            op_q   <= bus.op_i;
                            a_q    <= bus.a_i;
                            b_q    <= bus.b_i;
                            hilo_q <= bus.hilo_i;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= mdu_is_div(bus.op_i) ? DIV : MUL;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    MUL: begin
                        if (cnt == CNT_W'(MUL_STAGES)) begin
                            state    <= DONE;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            result_q <= pipe[MUL_STAGES-1];
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DIV: begin
                        // A zero divisor is spotted in the load cycle and bypasses the iterations.
                        if ((cnt == '0) && (b_q == '0)) begin
                            state    <= DONE;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            dbz_q    <= 1'b1;
                            result_q <= {a_q, {WIDTH{1'b1}}};
                        end else if (cnt == CNT_W'(WIDTH)) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    FIX: begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        result_q <= {r_fix, q_fix};
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.ready_o       = ready_q;
    assign bus.result_o      = result_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule
